// File: rtl/ws2812_frame_tx_pkg.sv
// Shared game definitions: GRB colour constants, WS2812 timing defaults and
// the frame transmitter state encoding.
package game_pkg;

   // Colours are packed {G,R,B}, matching the strip's wire order.
   localparam logic [23:0] OFF    = 24'h000000;
   localparam logic [23:0] RED    = 24'h00FF00;
   localparam logic [23:0] ORANGE = 24'h66FF00;
   localparam logic [23:0] GREEN  = 24'hFF0000;
   localparam logic [23:0] CYAN   = 24'hFF00FF;
   localparam logic [23:0] BLUE   = 24'h0000FF;
   localparam logic [23:0] VIOLET = 24'h0080FF;

   // Timing in 50 MHz clock cycles.
   localparam int unsigned DEF_T0H    = 20;
   localparam int unsigned DEF_T1H    = 40;
   localparam int unsigned DEF_TBIT   = 62;
   localparam int unsigned DEF_TLATCH = 3000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      LATCH = 2'd2
   } tx_state_e;

endpackage

// File: rtl/ws2812_frame_tx_if.sv
// GRBSeq frame handshake between the game engine (master) and the strip
// transmitter (slave).
interface ws2812_frame_tx_if #(
   parameter int unsigned FW = 120
) ();
   logic [FW-1:0] GRBSeq;
   logic          Start;
   logic          Busy;
   logic          Done;
   logic          DataOut;

   modport master (output GRBSeq, output Start,
                   input  Busy,   input  Done, input DataOut);
   modport slave  (input  GRBSeq, input  Start,
                   output Busy,   output Done, output DataOut);
endinterface

// File: rtl/ws2812_frame_tx_bit_cell.sv
// One WS2812 bit cell: TBIT-cycle counter, registered high/low waveform and
// an end-of-cell pulse. A start pulse on the last cycle chains the next cell.
module ws2812_bit_cell #(
   parameter int unsigned T0H  = 20,
   parameter int unsigned T1H  = 40,
   parameter int unsigned TBIT = 62
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic bit_val,
   output logic line,
   output logic cell_end
);
   localparam int unsigned CW = $clog2(TBIT);

   logic [CW-1:0] cnt;
   logic [CW-1:0] thr;
   logic          running;

   always_comb begin
      thr = bit_val ? CW'(T1H) : CW'(T0H);
   end

   assign cell_end = running && (cnt == CW'(TBIT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         running <= 1'b0;
         line    <= 1'b0;
      end else begin
         line <= running && (cnt < thr);
         if (start) begin
            cnt     <= '0;
            running <= 1'b1;
         end else if (cell_end) begin
            cnt     <= '0;
            running <= 1'b0;
         end else if (running) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ws2812_frame_tx.sv
// WS2812 frame transmitter: captures a packed GRB frame, sends it MSB-first
// as NRZ bit cells, then holds the line low for the latch gap and pulses Done.
module ws2812_frame_tx
   import game_pkg::*;
#(
   parameter int unsigned NUM_LEDS = 5,
   parameter int unsigned T0H      = DEF_T0H,
   parameter int unsigned T1H      = DEF_T1H,
   parameter int unsigned TBIT     = DEF_TBIT,
   parameter int unsigned TLATCH   = DEF_TLATCH
) (
   input  logic              clk,
   input  logic              reset,
   ws2812_frame_tx_if.slave  bus
);
   localparam int unsigned FW = 24 * NUM_LEDS;
   localparam int unsigned IW = $clog2(FW);
   localparam int unsigned LW = $clog2(TLATCH);

   tx_state_e     state, state_nxt;
   logic [FW-1:0] shadow;
   logic [IW-1:0] bit_idx;
   logic [LW-1:0] latch_cnt;
   logic          busy_q, busy_nxt;
   logic          done_q, done_nxt;
   logic          load, idx_dec, cell_start;
   logic          cell_end, line_q, bit_val, latch_end;

   assign bit_val   = shadow[bit_idx];
   assign latch_end = (latch_cnt == LW'(TLATCH - 1));

   ws2812_bit_cell #(
      .T0H  (T0H),
      .T1H  (T1H),
      .TBIT (TBIT)
   ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .start    (cell_start),
      .bit_val  (bit_val),
      .line     (line_q),
      .cell_end (cell_end)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         shadow    <= '0;
         bit_idx   <= '0;
         latch_cnt <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state  <= state_nxt;
         busy_q <= busy_nxt;
         done_q <= done_nxt;
         if (load) begin
            shadow  <= bus.GRBSeq;
            bit_idx <= IW'(FW - 1);
         end else if (idx_dec) begin
            bit_idx <= bit_idx - 1'b1;
         end
         latch_cnt <= (state == LATCH && !latch_end) ? latch_cnt + 1'b1 : '0;
      end
   end

   // The next cell is started on the same edge the current one ends, so cells
   // abut with no idle cycle and SEND lasts exactly FW*TBIT cycles.
   always_comb begin
      state_nxt  = state;
      busy_nxt   = 1'b0;
      done_nxt   = 1'b0;
      load       = 1'b0;
      idx_dec    = 1'b0;
      cell_start = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.Start) begin
               load       = 1'b1;
               cell_start = 1'b1;
               busy_nxt   = 1'b1;
               state_nxt  = SEND;
            end
         end
         SEND: begin
            busy_nxt = 1'b1;
            if (cell_end) begin
               if (bit_idx == '0) begin
                  state_nxt = LATCH;
               end else begin
                  idx_dec    = 1'b1;
                  cell_start = 1'b1;
               end
            end
         end
         LATCH: begin
            busy_nxt = 1'b1;
            if (latch_end) begin
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.Busy    = busy_q;
   assign bus.Done    = done_q;
   assign bus.DataOut = line_q;

endmodule

// File: tb/tb_ws2812_frame_tx.sv
// Randomised bench for ws2812_frame_tx against a cycle-indexed model of the
// NRZ waveform plus a bit-decoding monitor.
module tb_ws2812_frame_tx;
   import game_pkg::*;

   localparam int unsigned NUM_LEDS = 5;
   localparam int unsigned T0H      = 20;
   localparam int unsigned T1H      = 40;
   localparam int unsigned TBIT     = 62;
   localparam int unsigned TLATCH   = 3000;
   localparam int unsigned FW       = 24 * NUM_LEDS;
   localparam int          JDONE    = FW * TBIT + TLATCH;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   ws2812_frame_tx_if #(.FW(FW)) bus ();

   ws2812_frame_tx #(
      .NUM_LEDS (NUM_LEDS),
      .T0H      (T0H),
      .T1H      (T1H),
      .TBIT     (TBIT),
      .TLATCH   (TLATCH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Line level j cycles after the accepting edge: cell c occupies j=1+c*TBIT..
   function automatic logic exp_line(input logic [FW-1:0] f, input int j);
      int c, p;
      if (j < 1 || j > int'(FW * TBIT)) return 1'b0;
      c = (j - 1) / int'(TBIT);
      p = (j - 1) % int'(TBIT);
      return p < int'(f[FW-1-c] ? T1H : T0H);
   endfunction

   function automatic logic [FW-1:0] rand_frame();
      logic [127:0] t;
      t = {$urandom, $urandom, $urandom, $urandom};
      return t[FW-1:0];
   endfunction

   // Called at a falling edge; the frame is accepted on the next rising edge.
   task automatic run_frame(input string tag, input logic [FW-1:0] drv,
                            input logic [FW-1:0] expv, input bit disturb, input bit hold);
      int          mism = 0, edges = 0, nbits = 0, busy_len = 0, done_cnt = 0;
      int          hl = 0, first_rise = -1, bad_cell = 0;
      logic        prev = 1'b0, d;
      logic [FW-1:0] dec = '0;
      bus.GRBSeq = drv;
      bus.Start  = 1'b1;
      @(posedge clk);
      for (int j = 0; j <= JDONE; j++) begin
         @(negedge clk);
         d = bus.DataOut;
         if (d !== exp_line(expv, j)) mism++;
         if (bus.Busy !== (j < JDONE)) mism++;
         if (bus.Done !== (j == JDONE)) mism++;
         if (bus.Busy === 1'b1) busy_len++;
         if (bus.Done === 1'b1) done_cnt++;
         if (d !== prev) edges++;
         if (d === 1'b1 && prev !== 1'b1 && first_rise < 0) first_rise = j;
         if (d === 1'b1) hl++;
         if (d !== 1'b1 && prev === 1'b1) begin
            if (hl == int'(T1H)) dec = {dec[FW-2:0], 1'b1};
            else if (hl == int'(T0H)) dec = {dec[FW-2:0], 1'b0};
            else bad_cell++;
            nbits++;
            hl = 0;
         end
         prev = d;
         if (!hold)
            bus.Start = disturb && (j < JDONE - 1) && ($urandom_range(0, 19) == 0);
         if (disturb && j == 0) bus.GRBSeq = ~drv ^ rand_frame();
      end
      chk({tag, ".wave"}, mism, 0);
      chk({tag, ".frame"}, dec, expv);
      chk({tag, ".nbits"}, nbits, FW);
      chk({tag, ".badcell"}, bad_cell, 0);
      chk({tag, ".edges"}, edges, 2 * FW);
      chk({tag, ".busy_len"}, busy_len, JDONE);
      chk({tag, ".done_cnt"}, done_cnt, 1);
      chk({tag, ".first_rise"}, first_rise, 1);
   endtask

   task automatic after_done(input string tag);
      @(negedge clk);
      chk({tag, ".done_1cyc"}, bus.Done, 1'b0);
      chk({tag, ".idle_busy"}, bus.Busy, 1'b0);
   endtask

   initial begin
      #(120_000 * 10);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [FW-1:0] f, fa, fb;
      logic [FW-1:0] colours;
      reset      = 1'b1;
      bus.Start  = 1'b0;
      bus.GRBSeq = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset.dataout", bus.DataOut, 1'b0);
      chk("reset.busy", bus.Busy, 1'b0);
      chk("reset.done", bus.Done, 1'b0);
      reset = 1'b0;

      run_frame("zeros", '0, '0, 1'b0, 1'b0);
      after_done("zeros");
      run_frame("ones", '1, '1, 1'b0, 1'b0);
      after_done("ones");

      colours = 120'h00FF00_66FF00_000000_FF0000_0000FF;
      run_frame("colours", {RED, ORANGE, OFF, GREEN, BLUE}, colours, 1'b0, 1'b0);
      after_done("colours");

      // Abort partway through bit 50, then restart one cycle after release.
      @(negedge clk);
      bus.GRBSeq = rand_frame();
      bus.Start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.Start = 1'b0;
      repeat (50 * TBIT + 30) @(negedge clk);
      chk("abort.busy_pre", bus.Busy, 1'b1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort.dataout", bus.DataOut, 1'b0);
      chk("abort.busy", bus.Busy, 1'b0);
      chk("abort.done", bus.Done, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      chk("abort.done_post", bus.Done, 1'b0);
      chk("abort.busy_post", bus.Busy, 1'b0);

      f = rand_frame();
      run_frame("disturb", f, f, 1'b1, 1'b0);
      after_done("disturb");

      // Start held high: second frame accepted in the Done cycle.
      @(negedge clk);
      fa = rand_frame();
      fb = rand_frame();
      run_frame("held_a", fa, fa, 1'b0, 1'b1);
      run_frame("held_b", fb, fb, 1'b0, 1'b1);
      bus.Start = 1'b0;
      after_done("held_b");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
